// File: rtl/tlb_ctrl.sv
// TLB port sequencer: arbitrates fetch/data translations against CP0 TLB
// instructions, one operation at a time (IDLE -> EXEC -> RESP), and keeps CP0 Random.
module tlb_ctrl #(
  parameter int ENTRY_ADDR_WIDTH = 3
) (
  input  logic        clk,
  input  logic        res,
  input  logic        iReq,
  input  logic [31:0] iVAddr,
  output logic        iDone,
  output logic        iMiss,
  output logic        iInvalid,
  output logic [31:0] iPAddr,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [31:0] dVAddr,
  output logic        dDone,
  output logic        dMiss,
  output logic        dInvalid,
  output logic        dModified,
  output logic [31:0] dPAddr,
  input  logic        cmdValid,
  input  logic [1:0]  cmdOp,
  output logic        cmdDone,
  input  logic [31:0] indexIn,
  input  logic [31:0] wiredIn,
  input  logic [31:0] entryHiIn,
  output logic [31:0] indexOut,
  output logic        indexWe,
  output logic [31:0] rdEntryHi,
  output logic [31:0] rdEntryLo0,
  output logic [31:0] rdEntryLo1,
  output logic [31:0] rdPageMask,
  output logic        rdWe,
  output logic [31:0] random,
  output logic [31:0] tlbVAddr,
  output logic [31:0] tlbIndex,
  output logic        tlbRe,
  output logic        tlbWe,
  input  logic [31:0] tlbPAddr,
  input  logic [31:0] tlbMatchedIndex,
  input  logic        tlbFound,
  input  logic        tlbBitD,
  input  logic        tlbBitV,
  input  logic [31:0] tlbEntryHi,
  input  logic [31:0] tlbEntryLo0,
  input  logic [31:0] tlbEntryLo1,
  input  logic [31:0] tlbPageMask
);

  localparam int AW = ENTRY_ADDR_WIDTH;
  localparam int ENTRY_COUNT = 1 << AW;
  localparam logic [AW-1:0] RAND_TOP = AW'(ENTRY_COUNT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SRC_I = 2'd0;
  localparam logic [1:0] SRC_D = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;

  localparam logic [1:0] OP_TLBP  = 2'd0;
  localparam logic [1:0] OP_TLBR  = 2'd1;
  localparam logic [1:0] OP_TLBWI = 2'd2;

  logic [1:0]    state;
  logic [1:0]    src_p0;
  logic [1:0]    op_p0;
  logic          last_d;
  logic [AW-1:0] rand_q;
  logic [31:0]   vaddr_p0;
  logic          dwrite_p0;
  logic [AW-1:0] rand_p0;
  logic          grant;
  logic [1:0]    grant_src;
  logic          unused_bits;

  function automatic logic [31:0] zext_idx(input logic [AW-1:0] v);
    return {{(32-AW){1'b0}}, v};
  endfunction

  function automatic logic [AW-1:0] next_random(input logic [AW-1:0] cur,
                                                input logic [31:0] wired);
    if (wired >= 32'(ENTRY_COUNT) || cur <= wired[AW-1:0])
      return RAND_TOP;
    return cur - AW'(1);
  endfunction

  assign random = zext_idx(rand_q);
  assign unused_bits = ^{entryHiIn[12:0], indexIn[31:AW]};

  // Grant: commands first; on an i/d tie, serve whoever did not win last.
  always_comb begin
    grant     = 1'b0;
    grant_src = SRC_I;
    if (state == S_IDLE) begin
      if (cmdValid) begin
        grant     = 1'b1;
        grant_src = SRC_C;
      end else if (iReq && (!dReq || last_d)) begin
        grant     = 1'b1;
        grant_src = SRC_I;
      end else if (dReq) begin
        grant     = 1'b1;
        grant_src = SRC_D;
      end
    end
  end

  // Stage p0: request captured at grant, consumed during EXEC
  always_ff @(posedge clk) begin
    if (grant) begin
      vaddr_p0  <= (grant_src == SRC_D) ? dVAddr : iVAddr;
      dwrite_p0 <= dWrite;
      rand_p0   <= rand_q;
    end
  end

  // EXEC drives the TLB port; it is idle in every other state.
  always_comb begin
    tlbVAddr = '0;
    tlbIndex = '0;
    tlbRe    = 1'b0;
    tlbWe    = 1'b0;
    if (state == S_EXEC) begin
      if (src_p0 != SRC_C) begin
        tlbVAddr = vaddr_p0;
      end else begin
        case (op_p0)
          OP_TLBP:  tlbVAddr = {entryHiIn[31:13], 13'b0};
          OP_TLBR: begin
            tlbRe    = 1'b1;
            tlbIndex = zext_idx(indexIn[AW-1:0]);
          end
          OP_TLBWI: begin
            tlbWe    = 1'b1;
            tlbIndex = zext_idx(indexIn[AW-1:0]);
          end
          default: begin
            tlbWe    = 1'b1;
            tlbIndex = zext_idx(rand_p0);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= S_IDLE;
      src_p0     <= SRC_I;
      op_p0      <= OP_TLBP;
      last_d     <= 1'b1;
      rand_q     <= RAND_TOP;
      iDone      <= 1'b0;
      iMiss      <= 1'b0;
      iInvalid   <= 1'b0;
      iPAddr     <= '0;
      dDone      <= 1'b0;
      dMiss      <= 1'b0;
      dInvalid   <= 1'b0;
      dModified  <= 1'b0;
      dPAddr     <= '0;
      cmdDone    <= 1'b0;
      indexOut   <= '0;
      indexWe    <= 1'b0;
      rdEntryHi  <= '0;
      rdEntryLo0 <= '0;
      rdEntryLo1 <= '0;
      rdPageMask <= '0;
      rdWe       <= 1'b0;
    end else begin
      rand_q  <= next_random(rand_q, wiredIn);
      iDone   <= 1'b0;
      dDone   <= 1'b0;
      cmdDone <= 1'b0;
      indexWe <= 1'b0;
      rdWe    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            state  <= S_EXEC;
            src_p0 <= grant_src;
            op_p0  <= cmdOp;
            if (grant_src == SRC_I) last_d <= 1'b0;
            else if (grant_src == SRC_D) last_d <= 1'b1;
          end
        end
        // Stage p1: TLB results registered; done strobes are visible during RESP
        S_EXEC: begin
          state <= S_RESP;
          case (src_p0)
            SRC_I: begin
              iPAddr   <= tlbPAddr;
              iMiss    <= ~tlbFound;
              iInvalid <= tlbFound & ~tlbBitV;
              iDone    <= 1'b1;
            end
            SRC_D: begin
              dPAddr    <= tlbPAddr;
              dMiss     <= ~tlbFound;
              dInvalid  <= tlbFound & ~tlbBitV;
              dModified <= tlbFound & tlbBitV & dwrite_p0 & ~tlbBitD;
              dDone     <= 1'b1;
            end
            default: begin
              cmdDone <= 1'b1;
              if (op_p0 == OP_TLBP) begin
                indexOut <= tlbFound ? tlbMatchedIndex : 32'h8000_0000;
                indexWe  <= 1'b1;
              end
              if (op_p0 == OP_TLBR) begin
                rdEntryHi  <= tlbEntryHi;
                rdEntryLo0 <= tlbEntryLo0;
                rdEntryLo1 <= tlbEntryLo1;
                rdPageMask <= tlbPageMask;
                rdWe       <= 1'b1;
              end
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: an 8-entry 4K-page TLB model on the lookup port, plus a
// shadow copy of written entries from which expected translations are derived.
module tb_tlb_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic res;
  logic iReq, iDone, iMiss, iInvalid;
  logic [31:0] iVAddr, iPAddr;
  logic dReq, dWrite, dDone, dMiss, dInvalid, dModified;
  logic [31:0] dVAddr, dPAddr;
  logic cmdValid, cmdDone;
  logic [1:0] cmdOp;
  logic [31:0] indexIn, wiredIn, entryHiIn, indexOut;
  logic indexWe, rdWe;
  logic [31:0] rdEntryHi, rdEntryLo0, rdEntryLo1, rdPageMask, random;
  logic [31:0] tlbVAddr, tlbIndex;
  logic tlbRe, tlbWe;
  logic [31:0] tlbPAddr, tlbMatchedIndex;
  logic tlbFound, tlbBitD, tlbBitV;
  logic [31:0] tlbEntryHi, tlbEntryLo0, tlbEntryLo1, tlbPageMask;
  logic [31:0] cp0_lo0, cp0_lo1, cp0_pm;

  logic [31:0] m_hi [N];
  logic [31:0] m_lo0 [N];
  logic [31:0] m_lo1 [N];
  logic [31:0] m_pm [N];
  logic        m_vld [N] = '{default: 1'b0};
  int          wr_count = 0;
  logic [31:0] lk_lo;

  logic [31:0] s_hi [N];
  logic [31:0] s_lo0 [N];
  logic [31:0] s_lo1 [N];
  logic [31:0] s_pm [N];
  logic        s_vld [N] = '{default: 1'b0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb_ctrl #(.ENTRY_ADDR_WIDTH(3)) dut (
    .clk(clk), .res(res),
    .iReq(iReq), .iVAddr(iVAddr), .iDone(iDone), .iMiss(iMiss), .iInvalid(iInvalid), .iPAddr(iPAddr),
    .dReq(dReq), .dWrite(dWrite), .dVAddr(dVAddr), .dDone(dDone), .dMiss(dMiss),
    .dInvalid(dInvalid), .dModified(dModified), .dPAddr(dPAddr),
    .cmdValid(cmdValid), .cmdOp(cmdOp), .cmdDone(cmdDone),
    .indexIn(indexIn), .wiredIn(wiredIn), .entryHiIn(entryHiIn),
    .indexOut(indexOut), .indexWe(indexWe),
    .rdEntryHi(rdEntryHi), .rdEntryLo0(rdEntryLo0), .rdEntryLo1(rdEntryLo1),
    .rdPageMask(rdPageMask), .rdWe(rdWe), .random(random),
    .tlbVAddr(tlbVAddr), .tlbIndex(tlbIndex), .tlbRe(tlbRe), .tlbWe(tlbWe),
    .tlbPAddr(tlbPAddr), .tlbMatchedIndex(tlbMatchedIndex), .tlbFound(tlbFound),
    .tlbBitD(tlbBitD), .tlbBitV(tlbBitV),
    .tlbEntryHi(tlbEntryHi), .tlbEntryLo0(tlbEntryLo0), .tlbEntryLo1(tlbEntryLo1),
    .tlbPageMask(tlbPageMask)
  );

  // TLB model: writes from CP0 registers on tlbWe, combinational lookup/read.
  always @(posedge clk) begin
    if (tlbWe) begin
      m_hi[tlbIndex[2:0]]  <= entryHiIn;
      m_lo0[tlbIndex[2:0]] <= cp0_lo0;
      m_lo1[tlbIndex[2:0]] <= cp0_lo1;
      m_pm[tlbIndex[2:0]]  <= cp0_pm;
      m_vld[tlbIndex[2:0]] <= 1'b1;
      wr_count <= wr_count + 1;
    end
  end

  always_comb begin
    tlbFound = 1'b0;
    tlbMatchedIndex = '0;
    tlbPAddr = '0;
    tlbBitV = 1'b0;
    tlbBitD = 1'b0;
    lk_lo = '0;
    for (int i = 0; i < N; i++) begin
      if (m_vld[i] && m_hi[i][31:13] == tlbVAddr[31:13]) begin
        tlbFound = 1'b1;
        tlbMatchedIndex = 32'(i);
        lk_lo = tlbVAddr[12] ? m_lo1[i] : m_lo0[i];
      end
    end
    if (tlbFound) begin
      tlbPAddr = {lk_lo[25:6], tlbVAddr[11:0]};
      tlbBitV = lk_lo[1];
      tlbBitD = lk_lo[2];
    end
    tlbEntryHi  = m_hi[tlbIndex[2:0]];
    tlbEntryLo0 = m_lo0[tlbIndex[2:0]];
    tlbEntryLo1 = m_lo1[tlbIndex[2:0]];
    tlbPageMask = m_pm[tlbIndex[2:0]];
  end

  function automatic int ref_next_random(input int r, input int wired);
    return (wired >= N || r <= wired) ? N - 1 : r - 1;
  endfunction

  // Returns {miss, invalid, modified, paddr} from the shadow entries.
  function automatic logic [34:0] ref_xlate(input logic [31:0] va, input logic wr, input logic is_d);
    logic found;
    logic [31:0] lo;
    logic miss, inv, mod;
    found = 1'b0;
    lo = '0;
    for (int i = 0; i < N; i++)
      if (!found && s_vld[i] && s_hi[i][31:13] == va[31:13]) begin
        found = 1'b1;
        lo = va[12] ? s_lo1[i] : s_lo0[i];
      end
    miss = !found;
    inv  = found && !lo[1];
    mod  = is_d && found && lo[1] && wr && !lo[2];
    return {miss, inv, mod, lo[25:6], va[11:0]};
  endfunction

  function automatic logic [31:0] ref_tlbp(input logic [31:0] hi);
    for (int i = 0; i < N; i++)
      if (s_vld[i] && s_hi[i][31:13] == hi[31:13]) return 32'(i);
    return 32'h8000_0000;
  endfunction

  task automatic shadow_write(input int idx);
    s_hi[idx] = entryHiIn; s_lo0[idx] = cp0_lo0; s_lo1[idx] = cp0_lo1; s_pm[idx] = cp0_pm;
    s_vld[idx] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); res = 1'b1;
    @(negedge clk); res = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, output int lat, output int done_n, output int we_n,
                         output logic [31:0] we_idx, output int idx_we_n, output int rd_we_n,
                         output int other_done);
    @(negedge clk);
    cmdValid = 1'b1; cmdOp = op;
    lat = -1; done_n = 0; we_n = 0; we_idx = '0; idx_we_n = 0; rd_we_n = 0; other_done = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (tlbWe) begin we_n++; we_idx = tlbIndex; end
      if (indexWe) idx_we_n++;
      if (rdWe) rd_we_n++;
      if (iDone || dDone) other_done++;
      if (cmdDone) begin
        done_n++;
        if (lat < 0) lat = n;
        cmdValid = 1'b0;
      end
    end
    cmdValid = 1'b0;
  endtask

  task automatic run_xlate(input logic is_d, input logic [31:0] va, input logic wr,
                           output int lat, output int done_n, output logic [2:0] flags,
                           output logic [31:0] pa);
    @(negedge clk);
    if (is_d) begin dReq = 1'b1; dVAddr = va; dWrite = wr; end
    else begin iReq = 1'b1; iVAddr = va; end
    lat = -1; done_n = 0; flags = '0; pa = '0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (is_d ? dDone : iDone) begin
        done_n++;
        if (lat < 0) begin
          lat = n;
          flags = is_d ? {dMiss, dInvalid, dModified} : {iMiss, iInvalid, 1'b0};
          pa = is_d ? dPAddr : iPAddr;
        end
        iReq = 1'b0; dReq = 1'b0;
      end
    end
    iReq = 1'b0; dReq = 1'b0;
  endtask

  task automatic test_reset();
    logic [299:0] outs;
    @(negedge clk); res = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin @(posedge clk); #1; end
      else #1;
      outs = {iDone, iMiss, iInvalid, iPAddr, dDone, dMiss, dInvalid, dModified, dPAddr, cmdDone,
              indexOut, indexWe, rdEntryHi, rdEntryLo0, rdEntryLo1, rdPageMask, rdWe,
              tlbVAddr, tlbIndex, tlbRe, tlbWe};
      checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", outs); end
      checks++; if (random !== 32'd7) begin errors++; $display("FAIL reset_random got=%0d exp=7", random); end
    end
    @(negedge clk); res = 1'b0;
  endtask

  task automatic test_random();
    int r, w;
    wiredIn = 32'd2;
    do_reset();
    r = N - 1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; r = ref_next_random(r, 2); end
      checks++; if (random !== 32'(r)) begin errors++; $display("FAIL random_seq[%0d] got=%0d exp=%0d", k, random, r); end
    end
    for (int p = 0; p < 5; p++) begin
      w = (p == 0) ? 9 : $urandom_range(0, 12);
      @(negedge clk); wiredIn = 32'(w);
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1; r = ref_next_random(r, w);
        checks++; if (random !== 32'(r)) begin errors++; $display("FAIL random_wired%0d got=%0d exp=%0d", w, random, r); end
      end
    end
    wiredIn = 32'd2;
  endtask

  task automatic test_tlbwi();
    int lat, done_n, we_n, idx_we_n, rd_we_n, other;
    logic [31:0] we_idx;
    entryHiIn = 32'h0040_2000; cp0_lo0 = (32'h123 << 6) | 32'h2; cp0_lo1 = 32'h0; cp0_pm = 32'h0;
    indexIn = 32'd3;
    run_cmd(2'd2, lat, done_n, we_n, we_idx, idx_we_n, rd_we_n, other);
    shadow_write(3);
    checks++; if (we_n != 1) begin errors++; $display("FAIL tlbwi_we_cycles got=%0d exp=1", we_n); end
    checks++; if (we_idx !== 32'd3) begin errors++; $display("FAIL tlbwi_index got=%0d exp=3", we_idx); end
    checks++; if (lat != 1 || done_n != 1) begin errors++; $display("FAIL tlbwi_done lat=%0d n=%0d exp lat=1 n=1", lat, done_n); end
    checks++; if (other != 0 || idx_we_n != 0 || rd_we_n != 0) begin errors++; $display("FAIL tlbwi_side_strobes got=%0d/%0d/%0d exp=0", other, idx_we_n, rd_we_n); end
  endtask

  task automatic test_translate();
    int lat, done_n;
    logic [2:0] flags;
    logic [31:0] pa;
    logic [34:0] exp;
    logic [31:0] vas [5] = '{32'h0040_2ABC, 32'h0040_2ABC, 32'h0040_2ABC, 32'h0040_3010, 32'h7FFF_0000};
    logic        isd [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        wrs [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      run_xlate(isd[k], vas[k], wrs[k], lat, done_n, flags, pa);
      exp = ref_xlate(vas[k], wrs[k], isd[k]);
      checks++; if (lat != 1 || done_n != 1) begin errors++; $display("FAIL xlate%0d_done lat=%0d n=%0d exp lat=1 n=1", k, lat, done_n); end
      checks++; if (flags !== exp[34:32]) begin errors++; $display("FAIL xlate%0d_flags got=%b exp=%b", k, flags, exp[34:32]); end
      if (exp[34:32] == 3'b000) begin
        checks++; if (pa !== exp[31:0]) begin errors++; $display("FAIL xlate%0d_pa got=%h exp=%h", k, pa, exp[31:0]); end
      end
    end
    checks++; if (iPAddr !== 32'h0012_3ABC || iMiss !== 1'b0) begin errors++; $display("FAIL ipaddr_hold got=%h/%b exp=00123abc/0", iPAddr, iMiss); end
    checks++; if (dMiss !== 1'b1 || dModified !== 1'b0) begin errors++; $display("FAIL dmiss_unmapped got=%b/%b exp=1/0", dMiss, dModified); end
  endtask

  task automatic test_tlbp();
    int lat, done_n, we_n, idx_we_n, rd_we_n, other;
    logic [31:0] we_idx;
    logic [31:0] his [2] = '{32'h7FFF_0000, 32'h0040_2000};
    for (int k = 0; k < 2; k++) begin
      entryHiIn = his[k];
      run_cmd(2'd0, lat, done_n, we_n, we_idx, idx_we_n, rd_we_n, other);
      checks++; if (indexOut !== ref_tlbp(his[k])) begin errors++; $display("FAIL tlbp%0d_index got=%h exp=%h", k, indexOut, ref_tlbp(his[k])); end
      checks++; if (idx_we_n != 1 || lat != 1 || we_n != 0) begin errors++; $display("FAIL tlbp%0d_strobes indexWe=%0d lat=%0d we=%0d exp 1/1/0", k, idx_we_n, lat, we_n); end
    end
  endtask

  task automatic test_tlbr();
    int lat, done_n, we_n, idx_we_n, rd_we_n, other;
    logic [31:0] we_idx;
    indexIn = 32'd3;
    run_cmd(2'd1, lat, done_n, we_n, we_idx, idx_we_n, rd_we_n, other);
    checks++; if ({rdEntryHi, rdEntryLo0, rdEntryLo1, rdPageMask} !== {s_hi[3], s_lo0[3], s_lo1[3], s_pm[3]}) begin
      errors++; $display("FAIL tlbr_data got=%h %h %h %h exp=%h %h %h %h", rdEntryHi, rdEntryLo0, rdEntryLo1, rdPageMask, s_hi[3], s_lo0[3], s_lo1[3], s_pm[3]);
    end
    checks++; if (rd_we_n != 1 || lat != 1 || we_n != 0) begin errors++; $display("FAIL tlbr_strobes rdWe=%0d lat=%0d we=%0d exp 1/1/0", rd_we_n, lat, we_n); end
  endtask

  task automatic test_tlbwr();
    int lat, done_n, we_n, idx_we_n, rd_we_n, other, r, w, n;
    logic [31:0] we_idx;
    for (int it = 0; it < 3; it++) begin
      w = $urandom_range(0, 6);
      wiredIn = 32'(w);
      do_reset();
      r = N - 1;
      n = $urandom_range(1, 9);
      for (int k = 0; k < n; k++) begin @(posedge clk); r = ref_next_random(r, w); end
      entryHiIn = (32'h4_0000 | ($urandom & 32'h3_FFF8) | 32'(r)) << 13;
      cp0_lo0 = $urandom & 32'h03FF_FFC6; cp0_lo1 = $urandom & 32'h03FF_FFC6;
      run_cmd(2'd3, lat, done_n, we_n, we_idx, idx_we_n, rd_we_n, other);
      shadow_write(r);
      checks++; if (we_n != 1 || we_idx !== 32'(r)) begin errors++; $display("FAIL tlbwr%0d idx=%0d cycles=%0d exp idx=%0d cycles=1", it, we_idx, we_n, r); end
      checks++; if (lat != 1) begin errors++; $display("FAIL tlbwr%0d_done got=%0d exp=1", it, lat); end
    end
  endtask

  task automatic test_random_xlate();
    int lat, done_n, we_n, idx_we_n, rd_we_n, other, e;
    logic [31:0] we_idx, va, tmp, pa;
    logic [2:0] flags;
    logic [34:0] exp;
    logic is_d, wr;
    for (int i = 0; i < N; i++) begin
      entryHiIn = (($urandom & 32'h7_FFF8) | 32'(i)) << 13;
      cp0_lo0 = $urandom & 32'h03FF_FFC6; cp0_lo1 = $urandom & 32'h03FF_FFC6; cp0_pm = 32'h0;
      indexIn = 32'(i);
      run_cmd(2'd2, lat, done_n, we_n, we_idx, idx_we_n, rd_we_n, other);
      shadow_write(i);
      checks++; if (we_idx !== 32'(i) || we_n != 1) begin errors++; $display("FAIL fill%0d idx=%0d cycles=%0d", i, we_idx, we_n); end
    end
    for (int k = 0; k < 24; k++) begin
      e = $urandom_range(0, N - 1);
      tmp = $urandom;
      va = ($urandom_range(0, 3) != 0) ? {s_hi[e][31:13], tmp[12:0]} : tmp;
      is_d = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      run_xlate(is_d, va, wr, lat, done_n, flags, pa);
      exp = ref_xlate(va, wr, is_d);
      checks++; if (lat != 1 || done_n != 1) begin errors++; $display("FAIL rnd%0d_done lat=%0d n=%0d exp lat=1 n=1", k, lat, done_n); end
      checks++; if (flags !== exp[34:32]) begin errors++; $display("FAIL rnd%0d_flags va=%h got=%b exp=%b", k, va, flags, exp[34:32]); end
      if (exp[34:32] == 3'b000) begin
        checks++; if (pa !== exp[31:0]) begin errors++; $display("FAIL rnd%0d_pa va=%h got=%h exp=%h", k, va, pa, exp[31:0]); end
      end
    end
  endtask

  // Grants repeat every 3 cycles; the done of grant k is seen one edge after it.
  task automatic test_back_to_back();
    int seq_a [4] = '{1, 2, 1, 2};
    int seq_b [4] = '{0, 1, 2, 1};
    logic [2:0] obs, exp;
    for (int part = 0; part < 2; part++) begin
      do_reset();
      iVAddr = {s_hi[0][31:13], 13'h0}; dVAddr = {s_hi[1][31:13], 13'h0}; dWrite = 1'b0;
      iReq = 1'b1; dReq = 1'b1;
      if (part == 1) begin cmdValid = 1'b1; cmdOp = 2'd0; end
      for (int n = 0; n < 12; n++) begin
        @(posedge clk); #1;
        obs = {cmdDone, iDone, dDone};
        exp = 3'b000;
        if (n % 3 == 1) exp = 3'b100 >> ((part == 0) ? seq_a[n / 3] : seq_b[n / 3]);
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b%0d_cyc%0d done c/i/d got=%b exp=%b", part, n, obs, exp); end
        if (cmdDone) cmdValid = 1'b0;
      end
      iReq = 1'b0; dReq = 1'b0; cmdValid = 1'b0;
    end
  endtask

  task automatic test_abort();
    int n0, dones, lat, done_n;
    logic [2:0] flags;
    logic [31:0] pa;
    wiredIn = 32'd2;
    do_reset();
    n0 = wr_count;
    cmdValid = 1'b1; cmdOp = 2'd3; iReq = 1'b1; iVAddr = {s_hi[2][31:13], 13'h0};
    @(posedge clk); #1;
    checks++; if (tlbWe !== 1'b1) begin errors++; $display("FAIL abort_exec_we got=%b exp=1", tlbWe); end
    res = 1'b1; #1;
    cmdValid = 1'b0; iReq = 1'b0;
    checks++; if (tlbWe !== 1'b0 || random !== 32'd7) begin errors++; $display("FAIL abort_in_reset we=%b random=%0d exp 0/7", tlbWe, random); end
    @(negedge clk); res = 1'b0;
    checks++; if (random !== 32'd7) begin errors++; $display("FAIL abort_random got=%0d exp=7", random); end
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (iDone || dDone || cmdDone || indexWe || rdWe || tlbWe) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    checks++; if (wr_count != n0) begin errors++; $display("FAIL abort_no_write got=%0d exp=%0d", wr_count - n0, 0); end
    run_xlate(1'b0, iVAddr, 1'b0, lat, done_n, flags, pa);
    checks++; if (lat != 1 || done_n != 1) begin errors++; $display("FAIL abort_then_idle lat=%0d n=%0d exp lat=1 n=1", lat, done_n); end
  endtask

  initial begin
    res = 1'b0; iReq = 1'b0; iVAddr = '0; dReq = 1'b0; dWrite = 1'b0; dVAddr = '0;
    cmdValid = 1'b0; cmdOp = 2'd0; indexIn = '0; wiredIn = 32'd2; entryHiIn = '0;
    cp0_lo0 = '0; cp0_lo1 = '0; cp0_pm = '0;
    test_reset();
    test_random();
    test_tlbwi();
    test_translate();
    test_tlbp();
    test_tlbr();
    test_tlbwr();
    test_random_xlate();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
